// File: rtl/rom_stream_reader.sv
// rom_stream_reader: fetches a run of consecutive words from a synchronous Rom
// (1-cycle registered read). It streams them out on a valid/ready interface
// and marks the final word with out_last.
module rom_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;   // addresses still to issue
  logic                  iss_q, iss_d;         // address on rom_addr this cycle
  logic                  iss_last_q, iss_last_d;
  logic                  iss2_q;               // rom_data valid this cycle
  logic                  iss2_last_q;

  logic [DATA_WIDTH:0]   mem_q [BUF_DEPTH];    // {last, data}
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q;

  logic                  credit_ok;
  logic                  buf_wr, buf_rd;
  logic                  head_last;
  logic [CW:0]           inflight;

  // Count buffered words plus both pipe stages so no fetched word can overflow the buffer.
  assign inflight  = {1'b0, count_q} + {{CW{1'b0}}, iss_q} + {{CW{1'b0}}, iss2_q};
  assign credit_ok = inflight < (CW+1)'(BUF_DEPTH);

  assign out_valid = (count_q != '0);
  assign head_last = mem_q[rptr_q][DATA_WIDTH];
  assign out_data  = mem_q[rptr_q][DATA_WIDTH-1:0];
  assign out_last  = out_valid & head_last;
  assign buf_wr    = iss2_q;
  assign buf_rd    = out_valid & out_ready;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign rom_addr  = addr_q;

  // FSM, issue address and pipe-stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      iss_q       <= 1'b0;
      iss_last_q  <= 1'b0;
      iss2_q      <= 1'b0;
      iss2_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      iss_q       <= iss_d;
      iss_last_q  <= iss_last_d;
      iss2_q      <= iss_q;
      iss2_last_q <= iss_last_q;
    end
  end

  // Next state and issue decision. The first address goes out on the accepting edge,
  // so a one-word transfer has nothing left to fetch and skips straight to DRAIN.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    iss_d      = 1'b0;
    iss_last_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d     = base_addr;
            remain_d   = length - 1'b1;
            iss_d      = 1'b1;
            iss_last_d = (length == (ADDR_WIDTH+1)'(1));
            state_d    = (length == (ADDR_WIDTH+1)'(1)) ? S_DRAIN : S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (credit_ok) begin
          addr_d     = addr_q + 1'b1;
          remain_d   = remain_q - 1'b1;
          iss_d      = 1'b1;
          iss_last_d = (remain_q == (ADDR_WIDTH+1)'(1));
          if (remain_q == (ADDR_WIDTH+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (buf_rd && head_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output buffer: circular FIFO written from rom_data, read on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (buf_wr) begin
        mem_q[wptr_q] <= {iss2_last_q, rom_data};
        wptr_q        <= wptr_q + PW'(1);
      end
      if (buf_rd) rptr_q <= rptr_q + PW'(1);
      if (buf_wr && !buf_rd)      count_q <= count_q + CW'(1);
      else if (!buf_wr && buf_rd) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Testbench for rom_stream_reader: Rom model, table-driven transfers,
// random transfers, and hand-written reset / ignored-start sequences.
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       busy, done;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_last;

  logic [7:0] rom [256];

  int checks = 0;
  int errors = 0;

  rom_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Synchronous Rom: data for the sampled address appears one cycle later.
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic [7:0] base;
    int         len;
    int         pct;        // out_ready probability in percent
    bit         poke;       // re-assert start while busy
    int         exp_first;  // cycle of first out_valid, -1 never, -2 unchecked
    int         exp_done;   // cycle of done pulse, -2 unchecked
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one transfer starting at a negedge; returns at a negedge after the
  // start-in-DONE probe. Expected words come from the Rom array directly.
  task automatic run_xfer(input logic [7:0] b, input int len, input int pct, input bit poke,
                          input int exp_first, input int exp_done);
    int         idx = 0;
    int         first_v = -1;
    int         done_c = -1;
    int         budget = 20 * len + 60;
    bit         fin = 0;
    bit         done_exp;
    bit         prev_stall = 0;
    bit         r;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;
    logic [7:0] a;
    start     = 1'b1;
    base_addr = b;
    length    = 9'(len);
    out_ready = 1'b0;
    done_exp  = (len == 0);
    for (int c = 1; c <= budget && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1 && len > 0) begin
        chk("first_addr", 32'(rom_addr), 32'(b));
        chk("busy_c1", 32'(busy), 32'd1);
      end
      chk("done", 32'(done), 32'(done_exp));
      chk("busy", 32'(busy), 32'(!done));
      if (out_valid) begin
        if (first_v < 0) first_v = c;
        if (idx >= len) begin
          chk("extra_valid", 32'(out_valid), 32'd0);
        end else begin
          a = b + 8'(idx);
          chk("data", 32'(out_data), 32'(rom[a]));
          chk("last", 32'(out_last), 32'(idx == len - 1));
        end
        if (prev_stall) begin
          chk("stall_data", 32'(out_data), 32'(prev_data));
          chk("stall_last", 32'(out_last), 32'(prev_last));
        end
      end
      if (done) begin
        done_c = c;
        fin    = 1;
        chk("word_count", 32'(idx), 32'(len));
      end else begin
        r = ($urandom_range(99) < 32'(pct));
        if (poke && c == 2) begin
          start     = 1'b1;
          base_addr = 8'h80;
          length    = 9'd5;
        end
        out_ready  = r;
        prev_stall = out_valid && !r;
        prev_data  = out_data;
        prev_last  = out_last;
        if (out_valid && r && idx < len) begin
          if (idx == len - 1) done_exp = 1;
          idx++;
        end
      end
    end
    if (!fin) chk("timeout_done", 32'(done), 32'd1);
    out_ready = 1'b0;
    if (exp_first != -2) chk("first_valid_cycle", 32'(first_v), 32'(exp_first));
    if (exp_done != -2)  chk("done_cycle", 32'(done_c), 32'(exp_done));
    // A start presented during the DONE cycle must be ignored.
    start     = 1'b1;
    base_addr = 8'h55;
    length    = 9'd3;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_busy", 32'(busy), 32'd0);
    chk("done_start_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("done_start_valid", 32'(out_valid), 32'd0);
    chk("done_start_busy2", 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);

    tbl[0] = '{base: 8'h00, len: 16,  pct: 100, poke: 1'b0, exp_first: 3,  exp_done: 19};
    tbl[1] = '{base: 8'hFE, len: 4,   pct: 100, poke: 1'b0, exp_first: 3,  exp_done: 7};
    tbl[2] = '{base: 8'h00, len: 0,   pct: 100, poke: 1'b0, exp_first: -1, exp_done: 1};
    tbl[3] = '{base: 8'h40, len: 32,  pct: 30,  poke: 1'b0, exp_first: 3,  exp_done: -2};
    tbl[4] = '{base: 8'h10, len: 12,  pct: 100, poke: 1'b1, exp_first: 3,  exp_done: 15};
    tbl[5] = '{base: 8'h00, len: 256, pct: 100, poke: 1'b1, exp_first: 3,  exp_done: 259};
    tbl[6] = '{base: 8'h33, len: 1,   pct: 100, poke: 1'b0, exp_first: 3,  exp_done: 4};
    tbl[7] = '{base: 8'hF0, len: 20,  pct: 60,  poke: 1'b0, exp_first: 3,  exp_done: -2};

    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_xfer(tbl[i].base, tbl[i].len, tbl[i].pct, tbl[i].poke, tbl[i].exp_first, tbl[i].exp_done);

    // Reset in the middle of a transfer, after three words have been taken.
    start = 1'b1; base_addr = 8'h10; length = 9'd8; out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) cnt++;
    end
    chk("pre_reset_words", 32'(cnt), 32'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    run_xfer(8'h20, 2, 100, 1'b0, 3, 5);

    // Random transfers.
    for (int k = 0; k < 6; k++)
      run_xfer(8'($urandom), int'($urandom_range(40)), int'($urandom_range(100, 20)), 1'b0, -2, -2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
